rhythm_judge: RTL
=================

# rhythm_judge

Multi-lane, parametrised note-judging engine for the rhythm game. It generalises the single-lane shifter/scorer to LANES independent note lanes with configurable map length, hit position, good window and point values. It sits between the debounced KEY inputs, the tick divider (clock_8hz-style strobe) and the HEX/LEDR/VGA display logic. It produces per-lane judgements plus aggregate score, combo and max-combo.

## Interface
Parameters:
- LANES, 2: number of note lanes (1..8)
- MAP_LEN, 192: bits per lane map
- HIT_POS, 2: bit index judged PERFECT
- GOOD_WIN, 1: ± distance judged GOOD; HIT_POS ≥ GOOD_WIN required
- VIEW, 10: lane bits exported for LEDs/VGA
- SCORE_W, 8 / COMBO_W, 8: counter widths
- PERFECT_PTS, 2 / GOOD_PTS, 1: points per hit

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle step strobe; lanes advance one bit per tick
- start  in  1  one-cycle pulse: load maps and play
- stop  in  1  one-cycle pulse: abort to idle
- map_in  in  LANES*MAP_LEN  lane i at [i*MAP_LEN +: MAP_LEN], bit 0 exits first
- button  in  LANES  one-cycle press pulses, active-high, already debounced/edge-detected
- lane_view  out  LANES*VIEW  lane i bits [VIEW:1]
- judge_valid  out  LANES  per-lane judgement strobe
- accuracy  out  2*LANES  per-lane code: 00 none, 01 perfect, 10 good, 11 miss
- score  out  SCORE_W  saturating total
- combo / max_combo  out  COMBO_W  current and best streak, saturating
- playing / done  out  1  state flags

## Operation
- States: IDLE, PLAY, DONE. The reset state is IDLE.
- IDLE → PLAY on start. Start loads all lanes from map_in and clears score, combo and max_combo.
- PLAY → IDLE on stop. Counters are held and lanes are cleared. If stop and start arrive together, stop wins.
- PLAY → DONE when every lane register is zero, evaluated after that cycle's updates. DONE → PLAY on start, which reloads.
- Buttons and ticks outside PLAY are ignored, and judge_valid stays 0.
- Per-lane press judgement operates on the pre-shift register.
  - If bit HIT_POS is set, the result is PERFECT.
  - Otherwise the lane searches distance d = 1..GOOD_WIN, checking the lower index (HIT_POS−d) before the higher index (HIT_POS+d). The first set bit gives GOOD.
  - The judged bit is cleared.
  - If no bit is set, the result is 00 (empty hit). judge_valid is still asserted, with no score or combo change.
- Miss: on a tick, if bit 0 is still set after press clearing, the lane reports 11 and the bit is shifted out.
- If a press and a miss occur on the same lane in the same cycle, the press judgement is reported. The miss still resets combo.
- Shift: on tick, each lane shifts right by 1 after press clearing. MSB fills with 0.
- Aggregation per cycle:
  - score += PERFECT_PTS·(#perfect) + GOOD_PTS·(#good), saturating at 2^SCORE_W−1.
  - combo_next = 0 if any lane missed; otherwise combo + (#perfect + #good), saturating.
  - max_combo = max(max_combo, combo_next).

## Timing
- Reset values: all registers 0, playing=0, done=0, lane_view=0, judge_valid=0, accuracy=0.
- Async assert; synchronous-safe deassert handled upstream.
- A press in cycle N gives judge_valid/accuracy in cycle N+1 (registered, one-cycle pulse). score, combo and lane_view also update at N+1.
- A tick-induced miss has the same one-cycle latency.
- start/load: playing=1 and lane_view reflect map_in in the cycle after start.
- Reset asserted mid-PLAY: immediate return to IDLE with all outputs zero. No partial judgement survives.

## Structure
- Package rhythm_pkg holds:
  - the accuracy codes ACC_NONE/PERFECT/GOOD/MISS. These values are shared with hex_accuracy.
  - the state enum.
  - a clog2 helper.
- Sub-module rhythm_lane: shift register, window search, clear and miss detect. It is instantiated LANES times in a generate loop.
- The top level holds the FSM, the adder/saturation logic and the combo tracking.

## Test plan
Bench configuration: LANES=2, MAP_LEN=16, HIT_POS=2, GOOD_WIN=1.
- Perfect hit: lane0 map 16'h0004, start, then button[0] with no tick → accuracy0=01, score=2, combo=1, lane0 bit2 cleared, done=1.
- Good and empty hit: lane0 map 16'h0008, press → 10, score=1. Then map 16'h0010, press → 00, score/combo unchanged.
- Miss: lane0 map 16'h0002, combo pre-set to 3 via three perfects, two ticks with no press → accuracy0=11 on the second tick, combo=0, max_combo=3.
- Simultaneous lanes: lane0 perfect press in the same cycle as a lane1 bit0 tick-miss → score +2, combo=0, judge_valid=2'b11.
- Saturation: SCORE_W=4, score=14, perfect → score=15. A further perfect keeps score at 15.
- Control: stop during PLAY → playing=0, score held. rst low mid-PLAY → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared types for the rhythm note-judging engine: accuracy codes (also decoded
// by hex_accuracy), the play-state enum and a width helper.
package rhythm_pkg;

  typedef enum logic [1:0] {
    ACC_NONE    = 2'b00,
    ACC_PERFECT = 2'b01,
    ACC_GOOD    = 2'b10,
    ACC_MISS    = 2'b11
  } acc_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rhythm_judge_if.sv
// Control/data bundle between the game controller side and rhythm_judge.
interface rhythm_judge_if #(
  parameter int LANES   = 2,
  parameter int MAP_LEN = 192,
  parameter int VIEW    = 10,
  parameter int SCORE_W = 8,
  parameter int COMBO_W = 8
);
  logic                     tick;
  logic                     start;
  logic                     stop;
  logic [LANES*MAP_LEN-1:0] map_in;
  logic [LANES-1:0]         button;
  logic [LANES*VIEW-1:0]    lane_view;
  logic [LANES-1:0]         judge_valid;
  logic [2*LANES-1:0]       accuracy;
  logic [SCORE_W-1:0]       score;
  logic [COMBO_W-1:0]       combo;
  logic [COMBO_W-1:0]       max_combo;
  logic                     playing;
  logic                     done;

  modport master (
    output tick, start, stop, map_in, button,
    input  lane_view, judge_valid, accuracy, score, combo, max_combo, playing, done
  );

  modport slave (
    input  tick, start, stop, map_in, button,
    output lane_view, judge_valid, accuracy, score, combo, max_combo, playing, done
  );
endinterface

// File: rtl/rhythm_lane.sv
// One note lane: map shift register, press window search with clearing of the
// judged note, and miss detection on the bit leaving at index 0.
module rhythm_lane
  import rhythm_pkg::*;
#(
  parameter int MAP_LEN  = 192,
  parameter int HIT_POS  = 2,
  parameter int GOOD_WIN = 1,
  parameter int VIEW     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [MAP_LEN-1:0] map_i,
  input  logic               press_i,
  input  logic               tick_i,
  output acc_e               code_o,
  output logic               miss_o,
  output logic               play_zero_o,
  output logic [VIEW-1:0]    view_o
);

  localparam logic [MAP_LEN-1:0] ONE = MAP_LEN'(1);

  logic [MAP_LEN-1:0] lane_q, lane_d;
  logic [MAP_LEN-1:0] pick_s, cleared_s, played_s;
  acc_e               code_s;

  // Window search: descending d so the nearest distance, lower side first, wins.
  always_comb begin
    pick_s = '0;
    code_s = ACC_NONE;
    if ((lane_q & (ONE << HIT_POS)) != '0) begin
      pick_s = ONE << HIT_POS;
      code_s = ACC_PERFECT;
    end else begin
      for (int d = GOOD_WIN; d >= 1; d--) begin
        if ((lane_q & (ONE << (HIT_POS - d))) != '0) begin
          pick_s = ONE << (HIT_POS - d);
          code_s = ACC_GOOD;
        end else if ((lane_q & (ONE << (HIT_POS + d))) != '0) begin
          pick_s = ONE << (HIT_POS + d);
          code_s = ACC_GOOD;
        end else begin
        end
      end
    end
  end

  assign cleared_s = press_i ? (lane_q & ~pick_s) : lane_q;
  assign played_s  = tick_i ? (cleared_s >> 1) : cleared_s;

  // Next lane contents: abort clears, start loads, otherwise play updates.
  always_comb begin
    if (clear_i) begin
      lane_d = '0;
    end else if (load_i) begin
      lane_d = map_i;
    end else begin
      lane_d = played_s;
    end
  end

  // Lane register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign code_o      = code_s;
  assign miss_o      = tick_i & cleared_s[0];
  assign play_zero_o = (played_s == '0);
  assign view_o      = lane_q[VIEW:1];

endmodule

// File: rtl/rhythm_judge.sv
// Multi-lane note judge: play-state FSM, per-cycle score/combo aggregation with
// saturation, and registered judgement strobes.
module rhythm_judge
  import rhythm_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int MAP_LEN     = 192,
  parameter int HIT_POS     = 2,
  parameter int GOOD_WIN    = 1,
  parameter int VIEW        = 10,
  parameter int SCORE_W     = 8,
  parameter int COMBO_W     = 8,
  parameter int PERFECT_PTS = 2,
  parameter int GOOD_PTS    = 1
) (
  input logic           clk,
  input logic           rst,
  rhythm_judge_if.slave bus
);

  localparam int CW = clog2(LANES + 1);
  localparam int AW = SCORE_W + 8;
  localparam int BW = COMBO_W + CW + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COMBO_W-1:0]   combo_q, combo_d;
  logic [COMBO_W-1:0]   max_combo_q, max_combo_d;
  logic [LANES-1:0]     judge_valid_q, judge_valid_d;
  logic [2*LANES-1:0]   accuracy_q, accuracy_d;
  logic                 playing_q, playing_d;
  logic                 done_q, done_d;

  logic                 in_play_s, load_s, clear_s, tick_s;
  logic [LANES-1:0]     press_s, miss_s, zero_s, jv_s;
  logic [2*LANES-1:0]   acc_s;
  acc_e                 code_s [LANES];
  logic [LANES*VIEW-1:0] view_s;
  logic [CW-1:0]        n_perf_s, n_good_s;
  logic                 miss_any_s;
  logic [AW-1:0]        score_sum_s;
  logic [SCORE_W-1:0]   score_sat_s;
  logic [BW-1:0]        combo_sum_s;
  logic [COMBO_W-1:0]   combo_nx_s;

  // Stop beats start; buttons and ticks only reach the lanes while playing.
  assign in_play_s = (state_q == S_PLAY);
  assign load_s    = !in_play_s && bus.start && !bus.stop;
  assign clear_s   = in_play_s && bus.stop;
  assign press_s   = bus.button & {LANES{in_play_s}};
  assign tick_s    = bus.tick & in_play_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rhythm_lane #(
      .MAP_LEN (MAP_LEN),
      .HIT_POS (HIT_POS),
      .GOOD_WIN(GOOD_WIN),
      .VIEW    (VIEW)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_s),
      .clear_i    (clear_s),
      .map_i      (bus.map_in[g*MAP_LEN +: MAP_LEN]),
      .press_i    (press_s[g]),
      .tick_i     (tick_s),
      .code_o     (code_s[g]),
      .miss_o     (miss_s[g]),
      .play_zero_o(zero_s[g]),
      .view_o     (view_s[g*VIEW +: VIEW])
    );
  end

  // Per-lane reporting (a press outranks a same-lane miss) and hit counting.
  always_comb begin
    jv_s       = '0;
    acc_s      = '0;
    n_perf_s   = '0;
    n_good_s   = '0;
    miss_any_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (press_s[i]) begin
        jv_s[i]          = 1'b1;
        acc_s[2*i +: 2]  = code_s[i];
      end else if (miss_s[i]) begin
        jv_s[i]          = 1'b1;
        acc_s[2*i +: 2]  = ACC_MISS;
      end else begin
      end
      if (press_s[i] && (code_s[i] == ACC_PERFECT)) begin
        n_perf_s = n_perf_s + CW'(1);
      end else if (press_s[i] && (code_s[i] == ACC_GOOD)) begin
        n_good_s = n_good_s + CW'(1);
      end else begin
      end
      miss_any_s = miss_any_s | miss_s[i];
    end
  end

  assign score_sum_s = AW'(score_q) + AW'(PERFECT_PTS) * AW'(n_perf_s)
                     + AW'(GOOD_PTS) * AW'(n_good_s);
  assign score_sat_s = (score_sum_s > AW'(SCORE_MAX)) ? SCORE_MAX : score_sum_s[SCORE_W-1:0];
  assign combo_sum_s = BW'(combo_q) + BW'(n_perf_s) + BW'(n_good_s);
  assign combo_nx_s  = miss_any_s ? '0 :
                       ((combo_sum_s > BW'(COMBO_MAX)) ? COMBO_MAX : combo_sum_s[COMBO_W-1:0]);

  // Play-state FSM next state and counter updates.
  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    combo_d       = combo_q;
    max_combo_d   = max_combo_q;
    judge_valid_d = '0;
    accuracy_d    = '0;
    case (state_q)
      S_PLAY: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else begin
          judge_valid_d = jv_s;
          accuracy_d    = acc_s;
          score_d       = score_sat_s;
          combo_d       = combo_nx_s;
          max_combo_d   = (combo_nx_s > max_combo_q) ? combo_nx_s : max_combo_q;
          state_d       = (&zero_s) ? S_DONE : S_PLAY;
        end
      end
      S_IDLE, S_DONE: begin
        if (load_s) begin
          state_d     = S_PLAY;
          score_d     = '0;
          combo_d     = '0;
          max_combo_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    playing_d = (state_d == S_PLAY);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      score_q       <= '0;
      combo_q       <= '0;
      max_combo_q   <= '0;
      judge_valid_q <= '0;
      accuracy_q    <= '0;
      playing_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
      max_combo_q   <= max_combo_d;
      judge_valid_q <= judge_valid_d;
      accuracy_q    <= accuracy_d;
      playing_q     <= playing_d;
      done_q        <= done_d;
    end
  end

  assign bus.lane_view   = view_s;
  assign bus.judge_valid = judge_valid_q;
  assign bus.accuracy    = accuracy_q;
  assign bus.score       = score_q;
  assign bus.combo       = combo_q;
  assign bus.max_combo   = max_combo_q;
  assign bus.playing     = playing_q;
  assign bus.done        = done_q;

endmodule
